response_demux: RTL and testbench

RESPONSE_DEMUX -- requirements
Module: response_demux

---
 rtl/response_demux.sv | 106 ++++++++++
 tb/tb_response_demux.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/response_demux.sv
// rtl/response_demux.sv - routes upstream beats into per-port FIFOs by in_port_id.
// Optional per-port accept counters are built when RESPONSE_DEMUX_COUNT_EN is defined.
module response_demux #(
  parameter int NUM_OUTPUT_PORT = 2,
  parameter int DATA_WIDTH      = 64,
  parameter int FIFO_DEPTH      = 4,
  localparam int PID_W          = (NUM_OUTPUT_PORT > 1) ? $clog2(NUM_OUTPUT_PORT) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PID_W-1:0]           in_port_id,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic [NUM_OUTPUT_PORT-1:0] out_valid,
  input  logic [NUM_OUTPUT_PORT-1:0] out_ready,
  output logic [DATA_WIDTH-1:0]      out_data [NUM_OUTPUT_PORT],
  output logic                       err_bad_port,
  output logic [15:0]                accept_count [NUM_OUTPUT_PORT]
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]           wr_ptr [NUM_OUTPUT_PORT];
  logic [AW:0]           rd_ptr [NUM_OUTPUT_PORT];
  logic [DATA_WIDTH-1:0] mem    [NUM_OUTPUT_PORT][FIFO_DEPTH];

  logic [NUM_OUTPUT_PORT-1:0] full;
  logic [NUM_OUTPUT_PORT-1:0] empty;
  logic [NUM_OUTPUT_PORT-1:0] push;
  logic [NUM_OUTPUT_PORT-1:0] pop;
  logic                       id_ok;
  logic                       dest_full;

  // Ready looks only at the addressed FIFO's full flag, never at same-cycle pops.
  always_comb begin
    id_ok     = (int'(in_port_id) < NUM_OUTPUT_PORT);
    dest_full = 1'b0;
    full      = '0;
    empty     = '0;
    for (int i = 0; i < NUM_OUTPUT_PORT; i++) begin
      full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                 (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      if (in_port_id == PID_W'(i)) begin
        dest_full = full[i];
      end
    end
    in_ready = ~reset & ~(id_ok & dest_full);
  end

  always_comb begin
    push = '0;
    pop  = '0;
    for (int i = 0; i < NUM_OUTPUT_PORT; i++) begin
      push[i]     = in_valid & in_ready & id_ok & (in_port_id == PID_W'(i));
      pop[i]      = ~empty[i] & out_ready[i];
      out_valid[i] = ~empty[i];
      out_data[i]  = mem[i][rd_ptr[i][AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUTPUT_PORT; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      err_bad_port <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_OUTPUT_PORT; i++) begin
        if (push[i]) begin
          mem[i][wr_ptr[i][AW-1:0]] <= in_data;
          wr_ptr[i]                 <= wr_ptr[i] + PTR_ONE;
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
        end
      end
      // Out-of-range beats are swallowed; the flag stays set until reset.
      if (in_valid && in_ready && !id_ok) begin
        err_bad_port <= 1'b1;
      end
    end
  end

`ifdef RESPONSE_DEMUX_COUNT_EN
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_OUTPUT_PORT; i++) begin
      if (reset) begin
        accept_count[i] <= '0;
      end else if (push[i] && accept_count[i] != 16'hFFFF) begin
        accept_count[i] <= accept_count[i] + 16'd1;
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_OUTPUT_PORT; i++) begin
      accept_count[i] = '0;
    end
  end
`endif

endmodule

// File: tb/tb_response_demux.sv
// tb/tb_response_demux.sv - randomized and directed bench for response_demux against a queue model.
module tb_response_demux;

  localparam int NP    = 3;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int PW    = 2;
`ifdef RESPONSE_DEMUX_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_port_id;
  logic [DW-1:0] in_data;
  logic [NP-1:0] out_valid;
  logic [NP-1:0] out_ready;
  logic [DW-1:0] out_data [NP];
  logic          err_bad_port;
  logic [15:0]   accept_count [NP];

  response_demux #(.NUM_OUTPUT_PORT(NP), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_port_id(in_port_id), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .err_bad_port(err_bad_port),
    .accept_count(accept_count)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: one queue per port, sticky error, saturating counts.
  logic [DW-1:0] q [NP][$];
  int            mcnt   [NP];
  int            rx_cnt [NP];
  bit            merr = 1'b0;
  bit            started = 1'b0;
  bit            exp_rdy;
  int            idv;

  always @(negedge clk) begin
    if (started) begin
      idv = int'(in_port_id);
      if (reset) exp_rdy = 1'b0;
      else if (idv >= NP) exp_rdy = 1'b1;
      else exp_rdy = (q[idv].size() < DEPTH);
      chk("in_ready", in_ready, exp_rdy);
      chk("err_bad_port", err_bad_port, merr);
      for (int i = 0; i < NP; i++) begin
        chk($sformatf("out_valid[%0d]", i), out_valid[i], q[i].size() != 0);
        if (q[i].size() != 0) chk($sformatf("out_data[%0d]", i), out_data[i], q[i][0]);
        chk($sformatf("accept_count[%0d]", i), accept_count[i], COUNT_EN ? mcnt[i] : 0);
      end
      if (reset) begin
        for (int i = 0; i < NP; i++) begin
          q[i].delete();
          mcnt[i]   = 0;
          rx_cnt[i] = 0;
        end
        merr = 1'b0;
      end else begin
        for (int i = 0; i < NP; i++) begin
          if (q[i].size() != 0 && out_ready[i]) begin
            void'(q[i].pop_front());
            rx_cnt[i]++;
          end
        end
        if (in_valid && exp_rdy) begin
          if (idv < NP) begin
            q[idv].push_back(in_data);
            if (mcnt[idv] < 65535) mcnt[idv]++;
          end else begin
            merr = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
  endtask

  task automatic send(input int id, input logic [DW-1:0] d, input bit rnd);
    int n;
    in_valid   = 1'b1;
    in_port_id = PW'(id);
    in_data    = d;
    for (n = 0; n < 200; n++) begin
      if (rnd) out_ready = NP'($urandom);
      @(negedge clk);
      if (in_ready) break;
      tick();
    end
    chk("send_timeout", n < 200, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_port_id = '0; in_data = '0; out_ready = '0;
    tick();
    started = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_err", err_bad_port, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // In-order delivery on port 1 with only port 1 ready.
    tick();
    out_ready = 3'b010; in_valid = 1'b1; in_port_id = 2'd1; in_data = 16'hA0A0;
    tick();
    in_data = 16'hB1B1;
    @(negedge clk);
    chk("ord_valid_a", out_valid, 3'b010);
    chk("ord_data_a", out_data[1], 16'hA0A0);
    tick();
    in_data = 16'hC2C2;
    @(negedge clk);
    chk("ord_data_b", out_data[1], 16'hB1B1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("ord_data_c", out_data[1], 16'hC2C2);
    chk("ord_valid_c", out_valid, 3'b010);
    tick();
    @(negedge clk);
    chk("ord_drained", out_valid, 0);

    // Full backpressure on port 0.
    tick();
    reset_dut();
    out_ready = '0; in_valid = 1'b1; in_port_id = 2'd0;
    for (int k = 0; k < 4; k++) begin
      in_data = 16'(16'h0D00 + k);
      tick();
    end
    in_data = 16'h0D04;
    @(negedge clk);
    chk("bp_full_ready", in_ready, 0);
    tick();
    out_ready = 3'b001;
    @(negedge clk);
    chk("bp_pop_cycle_ready", in_ready, 0);
    chk("bp_head", out_data[0], 16'h0D00);
    tick();
    out_ready = '0;
    @(negedge clk);
    chk("bp_after_pop_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_count", accept_count[0], COUNT_EN ? 5 : 0);
    chk("bp_ready_full_again", in_ready, 0);
    tick();

    // Wrap-around: 20 alternating beats, random consumer readiness.
    reset_dut();
    for (int k = 0; k < 20; k++) send(k % 2, DW'($urandom), 1'b1);
    for (int k = 0; k < 40; k++) begin
      out_ready = NP'($urandom);
      tick();
    end
    out_ready = '1;
    repeat (10) tick();
    @(negedge clk);
    chk("wrap_rx0", rx_cnt[0], 10);
    chk("wrap_rx1", rx_cnt[1], 10);
    chk("wrap_cnt0", accept_count[0], COUNT_EN ? 10 : 0);
    chk("wrap_cnt1", accept_count[1], COUNT_EN ? 10 : 0);
    tick();

    // Randomized traffic including occasional out-of-range ids.
    reset_dut();
    for (int k = 0; k < 1500; k++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      in_port_id = ($urandom_range(0, 19) == 0) ? 2'd3 : PW'($urandom_range(0, 2));
      in_data    = DW'($urandom);
      out_ready  = NP'($urandom);
      tick();
    end
    in_valid = 1'b0;

    // Bad id.
    reset_dut();
    out_ready = '0; in_valid = 1'b1; in_port_id = 2'd3; in_data = 16'hBAD0;
    @(negedge clk);
    chk("bad_in_ready", in_ready, 1);
    chk("bad_err_before", err_bad_port, 0);
    tick();
    in_valid = 1'b0; in_port_id = 2'd0;
    @(negedge clk);
    chk("bad_err_set", err_bad_port, 1);
    chk("bad_no_valid", out_valid, 0);
    repeat (5) tick();
    @(negedge clk);
    chk("bad_err_sticky", err_bad_port, 1);
    tick();

    // Reset mid-operation with two held entries and a beat offered during reset.
    reset_dut();
    out_ready = '0;
    send(0, 16'h1111, 1'b0);
    send(0, 16'h2222, 1'b0);
    in_valid = 1'b1; in_port_id = 2'd0; in_data = 16'h3333;
    reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt", accept_count[0], 0);
    chk("mid_rst_err", err_bad_port, 0);
    tick();
    out_ready = '1;
    send(0, 16'h4444, 1'b0);
    @(negedge clk);
    chk("mid_rst_next_valid", out_valid[0], 1);
    chk("mid_rst_next_data", out_data[0], 16'h4444);
    tick();

    // Counter saturation on port 0.
    reset_dut();
    out_ready = '1; in_valid = 1'b1; in_port_id = 2'd0;
    for (int k = 0; k < 65540; k++) begin
      in_data = DW'(k);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("sat_count", accept_count[0], COUNT_EN ? 16'hFFFF : 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
